// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-side sram-like responder: the queued request
// record and the responder FSM state encoding.
package data_sram_responder_pkg;

    // One queued request as captured from the core's sram-like interface.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sramlike_req_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ISSUE,
        RESP
    } dresp_state_t;

    localparam int WCNT_W = 4;

endpackage

// File: rtl/sramlike_req_fifo.sv
// In-order request FIFO for the sram-like responder. Push is ignored when
// full and pop is ignored when empty, so callers may gate loosely.
module sramlike_req_fifo
    import data_sram_responder_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  sramlike_req_t push_data,
    input  logic          pop,
    output sramlike_req_t head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    sramlike_req_t mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    // Explicit wrap keeps DEPTH=1 correct where the pointer is wider than needed.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Entry storage; no reset needed since count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_inc(wptr);
            if (do_pop)  rptr <= ptr_inc(rptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Responder end of the data-side sram-like interface. Requests are queued in
// order, each one is issued to a synchronous word SRAM after WAIT_CYCLES
// wait states, and one data_data_ok pulse is returned per request.
//
// state | meaning
// IDLE  | queue empty, nothing in flight
// WAIT  | counting wait states before the head is issued
// ISSUE | ram_en high with the head request fields
// RESP  | data_data_ok high, SRAM read data passed through, head popped
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int QDEPTH      = 2,
    parameter int RAM_AW      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic [31:0]       data_rdata,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    dresp_state_t      state;
    logic [WCNT_W-1:0] wcnt;
    sramlike_req_t     req_in;
    sramlike_req_t     head;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [CW-1:0]     q_count_next;
    logic              push;
    logic              pop;
    logic              more_next;
    logic              unused_head;

    assign req_in = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

    // Acceptance depends only on the registered occupancy, never on a pop
    // happening in the same cycle.
    assign data_addr_ok = ~q_full;
    assign push         = data_req & data_addr_ok;
    assign pop          = (state == RESP);

    // Occupancy after this cycle decides whether another access follows.
    assign q_count_next = q_count + CW'(push) - CW'(pop);
    assign more_next    = (q_count_next != '0);

    // Size is carried for a future cache bridge; wstrb is authoritative.
    assign unused_head = ^{head.size, head.addr};

    sramlike_req_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (req_in),
        .pop       (pop),
        .head      (head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    // Responder sequencing: optional wait states, one-cycle issue, one-cycle response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (!more_next) begin
                        state <= IDLE;
                    end else if (WAIT_CYCLES > 0) begin
                        state <= WAIT;
                        wcnt  <= WAIT_LOAD;
                    end else begin
                        state <= ISSUE;
                    end
                end
                WAIT: begin
                    if (wcnt == '0) state <= ISSUE;
                    else            wcnt  <= wcnt - 1'b1;
                end
                ISSUE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // SRAM strobes and response outputs decode straight from the state
    // register so the head fields line up with ISSUE and RESP.
    always_comb begin
        ram_en       = 1'b0;
        ram_wen      = 4'b0;
        ram_addr     = '0;
        ram_wdata    = 32'h0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0;
        if (state == ISSUE) begin
            ram_en    = 1'b1;
            ram_wen   = head.wr ? head.wstrb : 4'b0;
            ram_addr  = head.addr[RAM_AW+1:2];
            ram_wdata = head.wdata;
        end
        if (state == RESP) begin
            data_data_ok = 1'b1;
            if (!head.wr) data_rdata = ram_rdata;
        end
    end

endmodule
